// File: rtl/drum_pkg.sv
// rtl/drum_pkg.sv - shared types, width defaults and saturating add for the DRUM pipeline
package drum_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int CNT_W_DEF  = 10;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Returns {carry, sum}; with sat set the sum pins at all-ones on carry.
    function automatic logic [ACC_W_DEF:0] sat_add(
        input logic [ACC_W_DEF-1:0] a,
        input logic [ACC_W_DEF-1:0] b,
        input logic                 sat
    );
        logic [ACC_W_DEF:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[ACC_W_DEF] && sat) begin
            s[ACC_W_DEF-1:0] = '1;
        end
        return s;
    endfunction

endpackage

// File: rtl/drum_prod_accumulator_if.sv
// rtl/drum_prod_accumulator_if.sv - product stream in, packet result out
interface drum_prod_accumulator_if #(
    parameter int PROD_W = drum_pkg::PROD_W_DEF,
    parameter int ACC_W  = drum_pkg::ACC_W_DEF,
    parameter int CNT_W  = drum_pkg::CNT_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/drum_sat_adder.sv
// rtl/drum_sat_adder.sv - accumulator plus zero-extended product, saturating or wrapping
module drum_sat_adder
    import drum_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF,
    parameter int SAT    = 1
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W:0] wide;

    always_comb begin
        wide  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        carry = wide[ACC_W];
        sum   = (carry && (SAT != 0)) ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
    end
endmodule

// File: rtl/drum_prod_accumulator.sv
// rtl/drum_prod_accumulator.sv - packet dot-product accumulator with held result handshake
module drum_prod_accumulator
    import drum_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    drum_prod_accumulator_if.slave bus
);
    acc_state_t       state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             ovf, ovf_next, carry;
    logic             accept;

    drum_sat_adder #(.ACC_W(ACC_W), .PROD_W(PROD_W), .SAT(SAT)) u_adder (
        .acc   (acc),
        .prod  (bus.in_prod),
        .sum   (acc_next),
        .carry (carry)
    );

    // in_ready depends only on state and reset, never on in_valid.
    assign bus.in_ready = (state == ACCUM) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign cnt_inc      = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign ovf_next     = ovf | carry;

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (accept && bus.in_last) state_next = HOLD;
            HOLD:  if (bus.out_ready)         state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ACCUM;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_count <= '0;
            bus.out_ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (bus.in_last) begin
                    bus.out_sum   <= acc_next;
                    bus.out_count <= cnt_inc;
                    bus.out_ovf   <= ovf_next;
                    bus.out_valid <= 1'b1;
                    acc           <= '0;
                    cnt           <= '0;
                    ovf           <= 1'b0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt_inc;
                    ovf <= ovf_next;
                end
            end else if (state == HOLD && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_drum_prod_accumulator.sv
// tb/tb_drum_prod_accumulator.sv - directed checks on saturating and wrapping accumulators
module tb_drum_prod_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    int          errors = 0;
    int          checks = 0;

    drum_prod_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(10)) ifs ();
    drum_prod_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(10)) ifw ();

    assign ifs.in_valid  = in_valid;
    assign ifs.in_prod   = in_prod;
    assign ifs.in_last   = in_last;
    assign ifs.out_ready = out_ready;
    assign ifw.in_valid  = in_valid;
    assign ifw.in_prod   = in_prod;
    assign ifw.in_last   = in_last;
    assign ifw.out_ready = out_ready;

    drum_prod_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(10), .SAT(1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (ifs)
    );

    drum_prod_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(10), .SAT(0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (ifw)
    );

    always #5 clk = ~clk;

    // Upstream must hold the beat while it is offered but not taken.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_prod  = '0;
    logic        prev_last  = 1'b0;
    always @(posedge clk) begin
        if (prev_stall && !rst && in_valid && (in_prod !== prev_prod || in_last !== prev_last)) begin
            errors++;
            $display("FAIL upstream_hold prod=%0h last=%0b required prod=%0h last=%0b",
                     in_prod, in_last, prev_prod, prev_last);
        end
        prev_stall <= in_valid && !ifs.in_ready;
        prev_prod  <= in_prod;
        prev_last  <= in_last;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ifs.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", ifs.out_valid); end
        checks++; if (ifs.out_sum !== 24'd0) begin errors++; $display("FAIL reset_out_sum got=%0h exp=0", ifs.out_sum); end
        checks++; if (ifs.out_count !== 10'd0) begin errors++; $display("FAIL reset_out_count got=%0d exp=0", ifs.out_count); end
        checks++; if (ifs.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got=%0b exp=0", ifs.out_ovf); end
        checks++; if (ifs.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", ifs.in_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] beats [3];
        beats[0] = 16'd3; beats[1] = 16'd5; beats[2] = 16'd7;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ifs.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready beat=%0d got=%0b exp=1", i, ifs.in_ready); end
            in_valid = 1'b1; in_prod = beats[i]; in_last = (i == 2);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (ifs.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%0b exp=1", ifs.out_valid); end
        checks++; if (ifs.out_sum !== 24'd15) begin errors++; $display("FAIL basic_out_sum got=%0d exp=15", ifs.out_sum); end
        checks++; if (ifs.out_count !== 10'd3) begin errors++; $display("FAIL basic_out_count got=%0d exp=3", ifs.out_count); end
        checks++; if (ifs.out_ovf !== 1'b0) begin errors++; $display("FAIL basic_out_ovf got=%0b exp=0", ifs.out_ovf); end
        checks++; if (ifs.in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_in_ready got=%0b exp=0", ifs.in_ready); end
        @(negedge clk);
        checks++; if (ifs.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop_valid got=%0b exp=0", ifs.out_valid); end
        checks++; if (ifs.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got=%0b exp=1", ifs.in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_prod = 16'h1234; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_prod = 16'h0;
        checks++; if (ifs.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%0b exp=1", ifs.out_valid); end
        checks++; if (ifs.out_sum !== 24'h001234) begin errors++; $display("FAIL single_out_sum got=%0h exp=1234", ifs.out_sum); end
        checks++; if (ifs.out_count !== 10'd1) begin errors++; $display("FAIL single_out_count got=%0d exp=1", ifs.out_count); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_prod = 16'd10; in_last = 1'b0;
        @(negedge clk);
        in_prod = 16'd20; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ifs.out_valid !== 1'b1 || ifs.out_sum !== 24'd30 || ifs.out_count !== 10'd2)
                begin errors++; $display("FAIL stall_hold cyc=%0d valid=%0b sum=%0d cnt=%0d exp valid=1 sum=30 cnt=2", i, ifs.out_valid, ifs.out_sum, ifs.out_count); end
            checks++; if (ifs.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", i, ifs.in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (ifs.out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got=%0b exp=0", ifs.out_valid); end
        checks++; if (ifs.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%0b exp=1", ifs.in_ready); end
        in_valid = 1'b1; in_prod = 16'd1; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (ifs.out_sum !== 24'd1 || ifs.out_count !== 10'd1 || ifs.out_valid !== 1'b1)
            begin errors++; $display("FAIL stall_next_pkt sum=%0d cnt=%0d valid=%0b exp sum=1 cnt=1 valid=1", ifs.out_sum, ifs.out_count, ifs.out_valid); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_valid = 1'b1; in_prod = 16'hFFFF; in_last = (i == 256);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; in_prod = 16'h0;
        checks++; if (ifs.out_sum !== 24'hFFFFFF) begin errors++; $display("FAIL ovf_sat_sum got=%0h exp=ffffff", ifs.out_sum); end
        checks++; if (ifs.out_count !== 10'd257) begin errors++; $display("FAIL ovf_sat_count got=%0d exp=257", ifs.out_count); end
        checks++; if (ifs.out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sat_flag got=%0b exp=1", ifs.out_ovf); end
        checks++; if (ifw.out_sum !== 24'h00FEFF) begin errors++; $display("FAIL ovf_wrap_sum got=%0h exp=00feff", ifw.out_sum); end
        checks++; if (ifw.out_count !== 10'd257) begin errors++; $display("FAIL ovf_wrap_count got=%0d exp=257", ifw.out_count); end
        checks++; if (ifw.out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_wrap_flag got=%0b exp=1", ifw.out_ovf); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid = 1'b1; in_prod = 16'd100; in_last = 1'b0;
        @(negedge clk);
        in_prod = 16'd200;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (ifs.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_during_valid got=%0b exp=0", ifs.out_valid); end
        checks++; if (ifs.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_during_ready got=%0b exp=0", ifs.in_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ifs.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after_valid got=%0b exp=0", ifs.out_valid); end
        in_valid = 1'b1; in_prod = 16'd4; in_last = 1'b0;
        @(negedge clk);
        in_prod = 16'd6; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (ifs.out_sum !== 24'd10) begin errors++; $display("FAIL rstmid_sum got=%0d exp=10", ifs.out_sum); end
        checks++; if (ifs.out_count !== 10'd2) begin errors++; $display("FAIL rstmid_count got=%0d exp=2", ifs.out_count); end
        checks++; if (ifs.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid got=%0b exp=1", ifs.out_valid); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_stall();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/drum_prod_accumulator.md
Name: drum_prod_accumulator

Overview:
- Downstream consumer of the 8x8 unsigned DRUM approximate multiplier: takes its 16-bit product stream and accumulates it into a dot-product sum.
- Packets are delimited by in_last.
- Each completed sum is emitted on a valid/ready output port with a beat count and an overflow flag.
- Sits between the combinational multiplier and the downstream filter/convolution consumer, and adds the design's first registered stage and flow control.

Parameters:
- PROD_W, 16, input product width; matches the 8+8 multiplier output.
- ACC_W, 24, accumulator and output sum width; must be >= PROD_W.
- CNT_W, 10, beat counter width.
- SAT, 1, 1 = saturate accumulator at all-ones on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  product beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_prod  in  PROD_W  approximate product (unsigned).
- in_last  in  1  beat is the final one of its packet.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- out_sum  out  ACC_W  packet sum.
- out_count  out  CNT_W  number of beats in the packet; saturates at 2^CNT_W-1.
- out_ovf  out  1  accumulator overflowed at least once in the packet.

Behaviour:
- Reset and clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = ACCUM; acc = 0; cnt = 0; ovf = 0.
  - out_valid = 0; out_sum = 0; out_count = 0; out_ovf = 0.
  - in_ready = 0 while rst is high.
- Accept rule: a beat is accepted when in_valid && in_ready. No beat is lost or duplicated.
- State ACCUM:
  - in_ready = 1.
  - On accept, sum = acc + zero-extended in_prod, computed ACC_W+1 bits wide.
  - If the carry bit is set: ovf_next = 1, and acc_next = all-ones (SAT=1) or the low ACC_W bits (SAT=0).
  - cnt increments and stops at its max.
  - If in_last is set on the accepted beat:
    - Load out_sum = acc_next, out_count = cnt+1 (saturated), out_ovf = ovf_next.
    - Set out_valid = 1 and clear acc, cnt and ovf.
    - Go to HOLD.
- State HOLD:
  - in_ready = 0.
  - out_* held stable while out_valid && !out_ready.
  - On out_ready: out_valid drops next cycle and the state returns to ACCUM.
  - in_ready rises in that same next cycle; there is no same-cycle bypass.
- Latency:
  - Result is visible the cycle after the last beat is accepted.
  - Minimum packet period with out_ready held high is N+1 cycles for N beats.
- Boundary cases:
  - A single-beat packet (in_last on the first beat) is legal; count = 1.
  - in_prod = 0 beats are counted.
  - in_valid low between beats is legal; the accumulator state holds.
  - in_last with in_valid low is ignored.
  - Reset mid-packet discards the partial sum and any pending result.
  - Reset wins over simultaneous accept or output handshake.
- Protocol assumptions and checks:
  - Inputs may change freely while in_ready = 0.
  - Upstream must hold in_prod/in_last stable while in_valid && !in_ready. The bench asserts this; the RTL does not check it.
- No combinational path from in_valid to in_ready. out_valid is registered.

Decomposition:
- Shared package drum_pkg holds:
  - The state enum (ACCUM, HOLD).
  - Default width constants PROD_W_DEF = 16, ACC_W_DEF = 24, CNT_W_DEF = 10.
  - A saturating-add function, reused by later DRUM pipeline stages.
- Natural sub-module: drum_sat_adder (parameterised ACC_W adder with SAT select and carry-out).
- The top level holds the FSM, counter and output registers.

Test Plan:
- Sum of 3, 5, 7 with in_last on 7, out_ready = 1 -> next cycle out_valid = 1, out_sum = 15, out_count = 3, out_ovf = 0; in_ready returns 1 one cycle later.
- Single beat 0x1234 with in_last -> out_sum = 0x001234, out_count = 1.
- Packet 10, 20 last, with out_ready = 0 for 5 cycles -> out_sum = 30 stable and in_ready = 0 throughout; handshake on cycle 6; then the next packet 1 last -> 1.
- SAT = 1: 257 beats of 0xFFFF, last on beat 257 -> out_sum = 0xFFFFFF, out_count = 257, out_ovf = 1.
- SAT = 0: same stimulus -> out_sum = 0x00FEFF, out_ovf = 1.
- Beats 100, 200, then rst for 1 cycle, then beats 4, 6 last -> out_sum = 10, out_count = 2; out_valid = 0 during and immediately after rst.
